// File: rtl/vlsu_pkg.sv
// Shared vector load/store unit definitions: load-packer FSM states, staging
// buffer size and the byte-lane compaction helper used by the load and store paths.
package vlsu_pkg;

    localparam int VREG_BYTES_DEF = 32;

    typedef enum logic [2:0] {
        LP_IDLE,
        LP_REQ,
        LP_RESP,
        LP_NEXT,
        LP_FLUSH
    } load_pack_state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  count;
    } compact_t;

    // Kept lanes land in ascending lane order starting at byte 0 of the result.
    function automatic compact_t compact_lanes(input logic [31:0] word, input logic [3:0] be);
        compact_t res;
        int       n;
        res = '0;
        n   = 0;
        for (int lane = 0; lane < 4; lane++) begin
            if (be[lane]) begin
                res.data[n*8 +: 8] = word[lane*8 +: 8];
                n++;
            end
        end
        res.count = 3'(n);
        return res;
    endfunction

endpackage

// File: rtl/vlsu_load_packer_if.sv
// Signal bundle between the load packer, the address unit, the data memory port
// and the VRF write port. The packer sits on the slave modport.
interface vlsu_load_packer_if
    import vlsu_pkg::*;
#(
    parameter int VREG_BYTES = VREG_BYTES_DEF
) ();

    // au_valid_i and au_next_o are single-cycle pulses; data_req_o is held with
    // stable addr/be until the cycle data_gnt_i is high (a same-cycle grant is
    // legal) and data_rvalid_i arrives no earlier than the cycle after the grant.
    logic                    start_i;
    logic                    au_valid_i;
    logic [31:0]             au_addr_i;
    logic [3:0]              au_be_i;
    logic [4:0]              au_vd_offset_i;
    logic                    au_final_i;
    logic                    au_next_o;
    logic                    data_req_o;
    logic [31:0]             data_addr_o;
    logic [3:0]              data_be_o;
    logic                    data_gnt_i;
    logic                    data_rvalid_i;
    logic [31:0]             data_rdata_i;
    logic                    wr_en_o;
    logic [VREG_BYTES*8-1:0] wr_data_o;
    logic [VREG_BYTES-1:0]   wr_be_o;
    logic                    done_o;
    logic                    overflow_o;
    load_pack_state_e        dbg_state;

    modport slave (
        input  start_i, au_valid_i, au_addr_i, au_be_i, au_vd_offset_i, au_final_i,
        input  data_gnt_i, data_rvalid_i, data_rdata_i,
        output au_next_o, data_req_o, data_addr_o, data_be_o,
        output wr_en_o, wr_data_o, wr_be_o, done_o, overflow_o, dbg_state
    );

    modport master (
        output start_i, au_valid_i, au_addr_i, au_be_i, au_vd_offset_i, au_final_i,
        output data_gnt_i, data_rvalid_i, data_rdata_i,
        input  au_next_o, data_req_o, data_addr_o, data_be_o,
        input  wr_en_o, wr_data_o, wr_be_o, done_o, overflow_o, dbg_state
    );

endinterface

// File: rtl/vlsu_byte_compactor.sv
// Squeezes the enabled byte lanes of a read word to the bottom and reports
// how many bytes were kept.
module vlsu_byte_compactor
    import vlsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [3:0]  be,
    output logic [31:0] packed_data,
    output logic [2:0]  count
);

    compact_t res;

    always_comb res = compact_lanes(rdata, be);

    assign packed_data = res.data;
    assign count       = res.count;

endmodule

// File: rtl/vlsu_load_packer.sv
// Load-data stage: one memory read per address-unit access, packs kept bytes into
// a staging buffer and emits a single masked VRF write after the final access.
module vlsu_load_packer
    import vlsu_pkg::*;
#(
    parameter int VREG_BYTES = VREG_BYTES_DEF
) (
    input logic               clk_i,
    input logic               n_rst_i,
    vlsu_load_packer_if.slave bus
);

    load_pack_state_e        state_q, state_d;
    logic [31:0]             addr_q;
    logic [3:0]              be_q;
    logic [4:0]              off_q;
    logic [VREG_BYTES*8-1:0] buf_q, buf_d;
    logic [VREG_BYTES-1:0]   mask_q, mask_d;
    logic                    ovf_q, ovf_d;
    logic                    final_q, final_d;
    logic                    resp_q, resp_d;
    logic                    latch_req;
    logic [31:0]             cmp_data;
    logic [2:0]              cmp_count;

    vlsu_byte_compactor u_compactor (
        .rdata       (bus.data_rdata_i),
        .be          (be_q),
        .packed_data (cmp_data),
        .count       (cmp_count)
    );

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= LP_IDLE;
            addr_q  <= '0;
            be_q    <= '0;
            off_q   <= '0;
            buf_q   <= '0;
            mask_q  <= '0;
            ovf_q   <= 1'b0;
            final_q <= 1'b0;
            resp_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            mask_q  <= mask_d;
            ovf_q   <= ovf_d;
            final_q <= final_d;
            resp_q  <= resp_d;
            if (latch_req) begin
                addr_q <= bus.au_addr_i;
                be_q   <= bus.au_be_i;
                off_q  <= bus.au_vd_offset_i;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        buf_d          = buf_q;
        mask_d         = mask_q;
        ovf_d          = ovf_q;
        final_d        = final_q | bus.au_final_i;
        resp_d         = resp_q;
        latch_req      = 1'b0;
        bus.au_next_o  = 1'b0;
        bus.data_req_o = 1'b0;
        bus.wr_en_o    = 1'b0;
        bus.done_o     = 1'b0;

        // start_i wipes the load context everywhere; a final arriving with it still counts.
        if (bus.start_i) begin
            buf_d   = '0;
            mask_d  = '0;
            ovf_d   = 1'b0;
            final_d = bus.au_final_i;
            resp_d  = 1'b0;
        end

        unique case (state_q)
            LP_IDLE: begin
                if (bus.au_valid_i) begin
                    latch_req = 1'b1;
                    state_d   = LP_REQ;
                end else if (final_d && resp_d) begin
                    state_d = LP_FLUSH;
                end
            end
            LP_REQ: begin
                bus.data_req_o = 1'b1;
                if (bus.start_i)         state_d = LP_IDLE;
                else if (bus.data_gnt_i) state_d = LP_RESP;
            end
            LP_RESP: begin
                if (bus.start_i) begin
                    state_d = LP_IDLE;
                end else if (bus.data_rvalid_i) begin
                    // Destination index is offset+k in 6 bits; anything past the buffer is dropped.
                    for (int j = 0; j < VREG_BYTES; j++) begin
                        for (int k = 0; k < 4; k++) begin
                            if (k < int'(cmp_count) && int'(off_q) + k == j) begin
                                buf_d[j*8 +: 8] = cmp_data[k*8 +: 8];
                                mask_d[j]       = 1'b1;
                            end
                        end
                    end
                    for (int k = 0; k < 4; k++) begin
                        if (k < int'(cmp_count) && int'(off_q) + k >= VREG_BYTES) ovf_d = 1'b1;
                    end
                    resp_d  = 1'b1;
                    state_d = LP_NEXT;
                end
            end
            LP_NEXT: begin
                if (bus.start_i) begin
                    state_d = LP_IDLE;
                end else if (final_d) begin
                    state_d = LP_FLUSH;
                end else begin
                    bus.au_next_o = 1'b1;
                    state_d       = LP_IDLE;
                end
            end
            LP_FLUSH: begin
                bus.wr_en_o = 1'b1;
                bus.done_o  = 1'b1;
                final_d     = bus.start_i & bus.au_final_i;
                resp_d      = 1'b0;
                state_d     = LP_IDLE;
            end
            default: state_d = LP_IDLE;
        endcase
    end

    assign bus.data_addr_o = addr_q;
    assign bus.data_be_o   = be_q;
    assign bus.wr_data_o   = buf_q;
    assign bus.wr_be_o     = mask_q;
    assign bus.overflow_o  = ovf_q;
    assign bus.dbg_state   = state_q;

    a_valid_only_in_idle: assert property (@(posedge clk_i) disable iff (!n_rst_i)
        bus.au_valid_i |-> state_q == LP_IDLE);

endmodule
